// File: rtl/izh_array.sv
// Time-multiplexed Izhikevich neuron array: one shared datapath updates one neuron per cycle.
// Sweep takes NUM_NEURONS cycles; define IZH_REFRACTORY_EN to add per-neuron refractory counters.
module izh_array #(
  parameter int NUM_NEURONS  = 8,
  parameter int WIDTH        = 16,
  parameter int FRAC         = 7,
  parameter int C_V2         = 5,
  parameter int C_V1         = 640,
  parameter int C_0          = 17920,
  parameter int A            = 3,
  parameter int B            = 26,
  parameter int C            = -8320,
  parameter int D            = 1024,
  parameter int THRESH       = 3840,
  parameter int V_INIT       = -8320,
  parameter int U_INIT       = -1664,
  parameter int REFRAC_STEPS = 2,
  localparam int IDXW        = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDXW-1:0]  cur_idx,
  input  logic [WIDTH-1:0] cur_in,
  output logic             spike_valid,
  output logic [IDXW-1:0]  spike_idx,
  input  logic [IDXW-1:0]  rd_idx,
  output logic [WIDTH-1:0] rd_v
);

  // Wide enough that coeff*v*v never overflows before the shift.
  localparam int EW = 2*WIDTH + 40;

  localparam logic signed [EW-1:0] K_V2 = EW'(C_V2);
  localparam logic signed [EW-1:0] K_V1 = EW'(C_V1);
  localparam logic signed [EW-1:0] K_0  = EW'(C_0);
  localparam logic signed [EW-1:0] K_A  = EW'(A);
  localparam logic signed [EW-1:0] K_B  = EW'(B);
  localparam logic signed [EW-1:0] K_D  = EW'(D);
  localparam logic signed [EW-1:0] K_TH = EW'(THRESH);
  localparam logic signed [EW-1:0] SMAX = {{(EW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]     C_W  = C[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     V_W  = V_INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     U_W  = U_INIT[WIDTH-1:0];

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  function automatic logic [WIDTH-1:0] sat(input logic signed [EW-1:0] x);
    if (x > SMAX)      return SMAX[WIDTH-1:0];
    else if (x < SMIN) return SMIN[WIDTH-1:0];
    else               return x[WIDTH-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic              spk_vld_q;
  logic [IDXW-1:0]   spk_idx_q;
  logic [WIDTH-1:0]  rd_v_q;
  logic              upd;

  logic [WIDTH-1:0]  v_q [NUM_NEURONS];
  logic [WIDTH-1:0]  u_q [NUM_NEURONS];

  logic [WIDTH-1:0]      v_old, u_old, v_new, u_new;
  logic signed [EW-1:0]  vx, ux, ix, b_term, v_int, u_int, u_spk;
  logic                  fire, fire_eff;

`ifdef IZH_REFRACTORY_EN
  localparam int RW = $clog2(REFRAC_STEPS + 2);
  logic [RW-1:0] ref_q [NUM_NEURONS];
  logic [RW-1:0] ref_new;
`endif

  always_comb begin
    v_old  = v_q[idx_q];
    u_old  = u_q[idx_q];
    vx     = {{(EW-WIDTH){v_old[WIDTH-1]}}, v_old};
    ux     = {{(EW-WIDTH){u_old[WIDTH-1]}}, u_old};
    ix     = {{(EW-WIDTH){cur_in[WIDTH-1]}}, cur_in};
    b_term = ((K_B * vx) >>> FRAC) - ux;
    v_int  = vx + ((K_V2 * vx * vx) >>> (2*FRAC)) + ((K_V1 * vx) >>> FRAC) + K_0 - ux + ix;
    u_int  = ux + ((K_A * b_term) >>> FRAC);
    u_spk  = ux + K_D;
    fire   = (vx >= K_TH);
  end

  always_comb begin
    v_new    = sat(v_int);
    u_new    = sat(u_int);
    fire_eff = fire;
`ifdef IZH_REFRACTORY_EN
    ref_new  = ref_q[idx_q];
    // A refractory neuron ignores its input and cannot fire until the count expires.
    if (ref_q[idx_q] != '0) begin
      v_new    = C_W;
      u_new    = u_old;
      fire_eff = 1'b0;
      ref_new  = ref_q[idx_q] - 1'b1;
    end else if (fire) begin
      v_new    = C_W;
      u_new    = sat(u_spk);
      ref_new  = RW'(REFRAC_STEPS);
    end
`else
    if (fire) begin
      v_new = C_W;
      u_new = sat(u_spk);
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    upd     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        upd = 1'b1;
        if (idx_q == IDXW'(NUM_NEURONS-1)) begin
          state_d = S_IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      spk_vld_q <= 1'b0;
      spk_idx_q <= '0;
      rd_v_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      spk_vld_q <= upd && fire_eff;
      if (upd && fire_eff) spk_idx_q <= idx_q;
      // Forward the value being written so a read of that neuron is never stale.
      rd_v_q    <= (upd && rd_idx == idx_q) ? v_new : v_q[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_NEURONS; k++) begin
        v_q[k] <= V_W;
        u_q[k] <= U_W;
`ifdef IZH_REFRACTORY_EN
        ref_q[k] <= '0;
`endif
      end
    end else if (upd) begin
      v_q[idx_q] <= v_new;
      u_q[idx_q] <= u_new;
`ifdef IZH_REFRACTORY_EN
      ref_q[idx_q] <= ref_new;
`endif
    end
  end

  assign busy        = (state_q == S_SWEEP);
  assign done        = done_q;
  assign cur_idx     = idx_q;
  assign spike_valid = spk_vld_q;
  assign spike_idx   = spk_idx_q;
  assign rd_v        = rd_v_q;

endmodule

// File: tb/tb_izh_array.sv
// Directed bench for izh_array: default-coefficient instance plus a linear-integrator instance.
module tb_izh_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start_d, start_l;
  logic        busy_d, done_d, sv_d, busy_l, done_l, sv_l;
  logic [2:0]  ci_d, si_d, ri_d, ci_l, si_l, ri_l;
  logic [15:0] cin_d, cin_l, rv_d, rv_l, lin_cur;

  int n_chk = 0;
  int n_err = 0;

  // Only neuron 5 of the linear instance receives current.
  assign cin_l = (ci_l == 3'd5) ? lin_cur : 16'd0;

  izh_array dut (
    .clk(clk), .reset_n(reset_n), .start(start_d), .busy(busy_d), .done(done_d),
    .cur_idx(ci_d), .cur_in(cin_d), .spike_valid(sv_d), .spike_idx(si_d),
    .rd_idx(ri_d), .rd_v(rv_d)
  );

  izh_array #(.C_V2(0), .C_V1(0), .C_0(0), .A(0), .V_INIT(0), .U_INIT(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .start(start_l), .busy(busy_l), .done(done_l),
    .cur_idx(ci_l), .cur_in(cin_l), .spike_valid(sv_l), .spike_idx(si_l),
    .rd_idx(ri_l), .rd_v(rv_l)
  );

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic rd(input bit l, input int k, output int val);
    @(negedge clk);
    if (l) ri_l = k[2:0];
    else   ri_d = k[2:0];
    @(negedge clk);
    val = l ? int'($signed(rv_l)) : int'($signed(rv_d));
  endtask

  task automatic sweep(input bit l, output int nspk, output int last_idx,
                       output int byp, output int first_idx);
    bit seen;
    nspk = 0; last_idx = -1; byp = 0; first_idx = -1; seen = 1'b0;
    @(negedge clk);
    if (l) start_l = 1'b1;
    else   start_d = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    start_d = 1'b0;
    first_idx = l ? int'(ci_l) : int'(ci_d);
    for (int c = 1; c <= 20 && !seen; c++) begin
      if (l ? sv_l : sv_d) begin
        nspk++;
        last_idx = l ? int'(si_l) : int'(si_d);
      end
      if (l && busy_l && ci_l == 3'd6) byp = int'($signed(rv_l));
      if (l ? done_l : done_d) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) chk("sweep_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int val, ns, li, byp, fi, tot, nd;
    reset_n = 1'b0; start_d = 1'b0; start_l = 1'b0;
    ri_d = '0; ri_l = '0; cin_d = '0; lin_cur = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_d, 0);
    chk("rst_done", done_d, 0);
    chk("rst_cur_idx", ci_d, 0);
    chk("rst_spike_valid", sv_d, 0);
    chk("rst_spike_idx", si_d, 0);
    chk("rst_rd_v", rv_d, 0);
    reset_n = 1'b1;
    rd(0, 0, val); chk("rst_v0", val, -8320);
    rd(0, 7, val); chk("rst_v7", val, -8320);

    // Sweep timing, with a second start during the sweep that must be ignored.
    @(negedge clk); start_d = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start_d = 1'b0;
      if (c == 3) start_d = 1'b1;
      if (c == 4) start_d = 1'b0;
      chk($sformatf("busy_c%0d", c), busy_d, (c <= 8) ? 1 : 0);
      chk($sformatf("done_c%0d", c), done_d, (c == 9) ? 1 : 0);
      if (c <= 8) chk($sformatf("cur_idx_c%0d", c), ci_d, c - 1);
    end

    // Reset in cycle 3 of a sweep.
    @(negedge clk); start_d = 1'b1;
    @(negedge clk); start_d = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy_d, 0);
    chk("midrst_done", done_d, 0);
    chk("midrst_cur_idx", ci_d, 0);
    chk("midrst_rd_v", rv_d, 0);
    @(negedge clk); reset_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_d) nd++;
    end
    chk("midrst_no_done", nd, 0);
    chk("midrst_idle", busy_d, 0);
    for (int k = 0; k < 8; k++) begin
      rd(0, k, val);
      chk($sformatf("midrst_v%0d", k), val, -8320);
    end

    // Default dynamics from rest, zero input.
    sweep(0, ns, li, byp, fi);
    chk("restart_first_idx", fi, 0);
    tot = ns;
    rd(0, 3, val); chk("dflt_v_s1", val, -9211);
    sweep(0, ns, li, byp, fi);
    tot += ns;
    rd(0, 3, val); chk("dflt_v_s2", val, -9790);
    for (int s = 3; s <= 100; s++) begin
      sweep(0, ns, li, byp, fi);
      tot += ns;
    end
    chk("dflt_no_spike", tot, 0);
    rd(0, 0, val);
    chk("dflt_v_range", (val >= -10240 && val <= -9000) ? 1 : 0, 1);

    // Linear integrator: +128 per sweep on neuron 5, threshold 3840 reached after 30 sweeps.
    do_reset();
    lin_cur = 16'd128;
    ri_l = 3'd5;
    sweep(1, ns, li, byp, fi);
    chk("lin_bypass", byp, 128);
    tot = ns;
    for (int s = 2; s <= 30; s++) begin
      sweep(1, ns, li, byp, fi);
      tot += ns;
    end
    chk("lin_no_early_spike", tot, 0);
    rd(1, 5, val); chk("lin_v5_s30", val, 3840);
    rd(1, 2, val); chk("lin_v2_s30", val, 0);
    sweep(1, ns, li, byp, fi);
    chk("lin_spike_cnt", ns, 1);
    chk("lin_spike_idx", li, 5);
    rd(1, 5, val); chk("lin_v5_reset", val, -8320);
    rd(1, 0, val); chk("lin_v0", val, 0);
    rd(1, 7, val); chk("lin_v7", val, 0);
    sweep(1, ns, li, byp, fi);
    tot = ns;
    rd(1, 5, val);
`ifdef IZH_REFRACTORY_EN
    chk("lin_v5_s32", val, -8320);
`else
    chk("lin_v5_s32", val, -9216);
`endif
    sweep(1, ns, li, byp, fi); tot += ns;
    sweep(1, ns, li, byp, fi); tot += ns;
    chk("lin_no_spike_after", tot, 0);
    rd(1, 5, val);
`ifdef IZH_REFRACTORY_EN
    chk("lin_v5_s34", val, -9216);
`else
    chk("lin_v5_s34", val, -11008);
`endif

    // Positive saturation, then a spike on the following sweep.
    do_reset();
    lin_cur = 16'd128;
    sweep(1, ns, li, byp, fi);
    sweep(1, ns, li, byp, fi);
    lin_cur = 16'h7FFF;
    sweep(1, ns, li, byp, fi);
    chk("sat_no_spike", ns, 0);
    rd(1, 5, val); chk("sat_pos_v5", val, 32767);
    lin_cur = 16'd0;
    sweep(1, ns, li, byp, fi);
    chk("sat_spike_cnt", ns, 1);
    chk("sat_spike_idx", li, 5);
    rd(1, 5, val); chk("sat_v5_reset", val, -8320);

    // Negative saturation must not wrap to a positive value.
    do_reset();
    lin_cur = 16'h8000;
    sweep(1, ns, li, byp, fi);
    rd(1, 5, val); chk("sat_neg_s1", val, -32768);
    sweep(1, ns, li, byp, fi);
    rd(1, 5, val); chk("sat_neg_s2", val, -32768);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
